// File: rtl/uart_rx_sequencer.sv
// Frame-level UART receive controller: arms on an idle line, gates the bit sampler for
// one frame, assembles the word and holds it in a single valid/ready output register.
module uart_rx_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_trigger,
    input  logic                 rx_sync,
    input  logic                 estimated_data,
    input  logic                 estimate_ready,
    output logic                 sampler_rst,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 parity_bit_q, parity_bit_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 parity_error_q, parity_error_d;
    logic                 overrun_q, overrun_d;
    logic                 sampler_rst_q, sampler_rst_d;
    logic                 busy_q, busy_d;
    logic                 parity_sum;
    logic                 parity_bad;
    logic                 can_load;

    assign parity_sum = (^shift_q) ^ parity_bit_q;
    assign can_load   = !data_valid_q || data_ready;

    always_comb begin
        parity_bad = 1'b0;
        if (PARITY == 1) begin
            parity_bad = parity_sum;
        end else if (PARITY == 2) begin
            parity_bad = ~parity_sum;
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        parity_bit_d   = parity_bit_q;
        data_valid_d   = data_valid_q;
        frame_error_d  = frame_error_q;
        parity_error_d = parity_error_q;
        overrun_d      = 1'b0;
        sampler_rst_d  = sampler_rst_q;
        busy_d         = busy_q;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                if (sample_trigger && rx_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sample_trigger && !rx_sync) begin
                    state_d       = ST_START;
                    sampler_rst_d = 1'b0;
                    busy_d        = 1'b1;
                end
            end
            ST_START: begin
                // A high start estimate means the falling edge was a glitch
                if (estimate_ready) begin
                    if (estimated_data) begin
                        state_d       = ST_IDLE;
                        sampler_rst_d = 1'b1;
                        busy_d        = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (estimate_ready) begin
                    shift_d = {estimated_data, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (estimate_ready) begin
                    parity_bit_d = estimated_data;
                    state_d      = ST_STOP;
                end
            end
            ST_STOP: begin
                // A full register that is not being drained loses the new frame
                if (estimate_ready) begin
                    state_d       = ST_WAIT_IDLE;
                    sampler_rst_d = 1'b1;
                    busy_d        = 1'b0;
                    if (can_load) begin
                        data_d         = shift_q;
                        frame_error_d  = ~estimated_data;
                        parity_error_d = parity_bad;
                        data_valid_d   = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d       = ST_WAIT_IDLE;
                sampler_rst_d = 1'b1;
                busy_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_WAIT_IDLE;
            shift_q        <= '0;
            data_q         <= '0;
            cnt_q          <= '0;
            parity_bit_q   <= 1'b0;
            data_valid_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            parity_error_q <= 1'b0;
            overrun_q      <= 1'b0;
            sampler_rst_q  <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            parity_bit_q   <= parity_bit_d;
            data_valid_q   <= data_valid_d;
            frame_error_q  <= frame_error_d;
            parity_error_q <= parity_error_d;
            overrun_q      <= overrun_d;
            sampler_rst_q  <= sampler_rst_d;
            busy_q         <= busy_d;
        end
    end

    assign sampler_rst  = sampler_rst_q;
    assign data         = data_q;
    assign data_valid   = data_valid_q;
    assign frame_error  = frame_error_q;
    assign parity_error = parity_error_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule
